plab4_net_router_input_ctrl_sep: RTL and testbench

Input-side controller for one router input port; it is the upstream counterpart of the per-output arbiter control in the ring router. It buffers incoming messages in a 2-entry queue and computes the ring route of the head message. It raises a request on exactly one of three separate per-output request wires, tagged with the message's security domain. When that output's arbiter grants, it dequeues the head and presents it to the crossbar.

---
 rtl/plab4_net_router_input_ctrl_sep_pkg.sv | 28 ++
 rtl/plab4_net_RouteCompute.sv | 17 +
 rtl/plab4_net_router_input_ctrl_sep.sv | 102 ++++++++++
 tb/tb_plab4_net_router_input_ctrl_sep.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/plab4_net_router_input_ctrl_sep_pkg.sv
// Shared encodings for the ring router: output port indices, input-queue
// occupancy states and the ring route function.
package plab4_net_router_input_ctrl_sep_pkg;

  localparam logic [1:0] PORT_WEST = 2'd0;
  localparam logic [1:0] PORT_TERM = 2'd1;
  localparam logic [1:0] PORT_EAST = 2'd2;

  // Occupancy of the 2-entry input queue; the encoding equals the entry count.
  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_e;

  // num_routers is a power of two, so the mask implements the modular wrap.
  // A destination exactly half-way round the ring goes east.
  function automatic logic [1:0] route_port(input logic [31:0] dest,
                                            input logic [31:0] router_id,
                                            input logic [31:0] num_routers);
    logic [31:0] fwd;
    fwd = (dest + num_routers - router_id) & (num_routers - 32'd1);
    if (fwd == 32'd0)                   return PORT_TERM;
    else if (fwd <= (num_routers >> 1)) return PORT_EAST;
    else                                return PORT_WEST;
  endfunction

endpackage

// File: rtl/plab4_net_RouteCompute.sv
// Combinational ring route: destination and router id to output port index.
module plab4_net_RouteCompute
  import plab4_net_router_input_ctrl_sep_pkg::*;
#(
  parameter int p_num_routers = 4,
  parameter int c_dest_nbits  = $clog2(p_num_routers)
) (
  input  logic [c_dest_nbits-1:0] dest,
  input  logic [c_dest_nbits-1:0] router_id,
  output logic [1:0]              port
);

  always_comb begin
    port = route_port(32'(dest), 32'(router_id), 32'(p_num_routers));
  end

endmodule

// File: rtl/plab4_net_router_input_ctrl_sep.sv
// Router input-port controller: 2-entry {domain, msg} queue, route of the
// head message, one-hot per-output requests and dequeue on matching grant.
module plab4_net_router_input_ctrl_sep
  import plab4_net_router_input_ctrl_sep_pkg::*;
#(
  parameter int p_router_id   = 0,
  parameter int p_num_routers = 4,
  parameter int p_msg_nbits   = 44,
  parameter int p_dest_msb    = 43,
  parameter int p_dest_lsb    = 42
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [p_msg_nbits-1:0] in_msg,
  input  logic                   in_domain,

  output logic                   reqs_p0,
  output logic                   reqs_p1,
  output logic                   reqs_p2,
  output logic                   reqs_domain,

  input  logic                   grants_p0,
  input  logic                   grants_p1,
  input  logic                   grants_p2,

  output logic [p_msg_nbits-1:0] out_msg,
  output logic                   out_domain
);

  localparam int c_dest_nbits = $clog2(p_num_routers);

  q_state_e               state_q, state_n;
  logic                   head_q, tail_q;
  logic [p_msg_nbits-1:0] msg_q [2];
  logic                   dom_q [2];

  logic                   nonempty;
  logic                   enq, deq;
  logic [1:0]             head_port;

  assign nonempty = (state_q != Q_EMPTY);
  assign in_rdy   = !reset && (state_q != Q_FULL);
  assign enq      = in_val && in_rdy;

  plab4_net_RouteCompute #(
    .p_num_routers (p_num_routers),
    .c_dest_nbits  (c_dest_nbits)
  ) route_compute (
    .dest      (msg_q[head_q][p_dest_msb:p_dest_lsb]),
    .router_id (c_dest_nbits'(p_router_id)),
    .port      (head_port)
  );

  // Requests and head data come from registered state only; grants feed
  // nothing but the dequeue decision sampled at the next edge.
  always_comb begin
    reqs_p0     = nonempty && (head_port == PORT_WEST);
    reqs_p1     = nonempty && (head_port == PORT_TERM);
    reqs_p2     = nonempty && (head_port == PORT_EAST);
    out_msg     = nonempty ? msg_q[head_q] : '0;
    out_domain  = nonempty && dom_q[head_q];
    reqs_domain = out_domain;
    deq         = (reqs_p0 && grants_p0) || (reqs_p1 && grants_p1)
               || (reqs_p2 && grants_p2);
  end

  always_comb begin
    state_n = state_q;
    if (enq && !deq) begin
      state_n = (state_q == Q_EMPTY) ? Q_ONE : Q_FULL;
    end else if (deq && !enq) begin
      state_n = (state_q == Q_FULL) ? Q_ONE : Q_EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= Q_EMPTY;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      if (enq) tail_q <= ~tail_q;
      if (deq) head_q <= ~head_q;
    end
  end

  // NOTE: queue storage is deliberately not reset; every read of it is
  // qualified by the occupancy state, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (enq) begin
      msg_q[tail_q] <= in_msg;
      dom_q[tail_q] <= in_domain;
    end
  end

endmodule

// File: tb/tb_plab4_net_router_input_ctrl_sep.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based reference model of the input controller (N=4, router id 1).
module tb_plab4_net_router_input_ctrl_sep;

  localparam int N    = 4;
  localparam int ID   = 1;
  localparam int MSGW = 44;

  typedef struct {
    logic            dom;
    logic [MSGW-1:0] msg;
  } ent_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_val, in_rdy, in_domain;
  logic [MSGW-1:0] in_msg;
  logic            reqs_p0, reqs_p1, reqs_p2, reqs_domain;
  logic            grants_p0, grants_p1, grants_p2;
  logic [MSGW-1:0] out_msg;
  logic            out_domain;

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t mq[$];

  always #5 clk = ~clk;

  plab4_net_router_input_ctrl_sep #(
    .p_router_id   (ID),
    .p_num_routers (N),
    .p_msg_nbits   (MSGW),
    .p_dest_msb    (43),
    .p_dest_lsb    (42)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_val      (in_val),
    .in_rdy      (in_rdy),
    .in_msg      (in_msg),
    .in_domain   (in_domain),
    .reqs_p0     (reqs_p0),
    .reqs_p1     (reqs_p1),
    .reqs_p2     (reqs_p2),
    .reqs_domain (reqs_domain),
    .grants_p0   (grants_p0),
    .grants_p1   (grants_p1),
    .grants_p2   (grants_p2),
    .out_msg     (out_msg),
    .out_domain  (out_domain)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Ring distance east, taken modulo N; 0 = local, up to N/2 = east, else west.
  function automatic int ref_port(input logic [1:0] d);
    int fwd;
    fwd = ((int'(d) - ID) % N + N) % N;
    if (fwd == 0)      return 1;
    else if (fwd <= N/2) return 2;
    else               return 0;
  endfunction

  // One cycle: drive inputs, check outputs mid-cycle against the model,
  // then advance the model at the clock edge.
  task automatic step(input bit rst, input bit val, input logic [1:0] dest,
                      input bit dom, input logic [2:0] g, input bit auto_g);
    logic [MSGW-1:0] m;
    logic [2:0]      gv;
    logic [2:0]      exp_reqs;
    logic [MSGW-1:0] exp_msg;
    logic            exp_dom;
    int              p;
    bit              do_enq, do_deq;
    m  = {dest, 10'($urandom), 32'($urandom)};
    gv = g;
    p  = 0;
    if (mq.size() > 0) p = ref_port(mq[0].msg[43:42]);
    if (auto_g && mq.size() > 0) gv[p] = 1'b1;
    reset = rst; in_val = val; in_msg = m; in_domain = dom;
    {grants_p2, grants_p1, grants_p0} = gv;
    @(negedge clk);
    exp_reqs = '0; exp_msg = '0; exp_dom = 1'b0;
    if (mq.size() > 0) begin
      exp_reqs = 3'(1 << p);
      exp_msg  = mq[0].msg;
      exp_dom  = mq[0].dom;
    end
    check("reqs", 64'({reqs_p2, reqs_p1, reqs_p0}), 64'(exp_reqs));
    check("reqs_domain", 64'(reqs_domain), 64'(exp_dom));
    check("out_domain", 64'(out_domain), 64'(exp_dom));
    check("out_msg", 64'(out_msg), 64'(exp_msg));
    check("in_rdy", 64'(in_rdy), 64'(!rst && mq.size() < 2));
    @(posedge clk);
    if (rst) begin
      mq.delete();
    end else begin
      do_deq = (mq.size() > 0) && gv[p];
      do_enq = val && (mq.size() < 2);
      if (do_deq) void'(mq.pop_front());
      if (do_enq) mq.push_back('{dom: dom, msg: m});
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; in_val = 1'b0; in_msg = '0; in_domain = 1'b0;
    grants_p0 = 1'b0; grants_p1 = 1'b0; grants_p2 = 1'b0;
    @(posedge clk); #1;
    step(1, 0, 2'd0, 0, 3'b000, 0);

    // Route table: dest 1,2,3,0 with immediate grants on the routed port.
    step(0, 1, 2'd1, 0, 3'b000, 1);
    step(0, 1, 2'd2, 1, 3'b000, 1);
    step(0, 1, 2'd3, 0, 3'b000, 1);
    step(0, 1, 2'd0, 1, 3'b000, 1);
    step(0, 0, 2'd0, 0, 3'b000, 1);
    step(0, 0, 2'd0, 0, 3'b000, 0);

    // Backpressure: third message refused, one grant reopens the queue.
    step(0, 1, 2'd1, 0, 3'b000, 0);
    step(0, 1, 2'd2, 1, 3'b000, 0);
    step(0, 1, 2'd3, 0, 3'b000, 0);
    step(0, 0, 2'd0, 0, 3'b000, 1);
    step(0, 0, 2'd0, 0, 3'b000, 0);
    step(0, 0, 2'd0, 0, 3'b000, 1);

    // Wrong grants on a head routed east are ignored.
    step(0, 1, 2'd2, 1, 3'b000, 0);
    step(0, 0, 2'd0, 0, 3'b011, 0);
    step(0, 0, 2'd0, 0, 3'b001, 0);
    step(0, 0, 2'd0, 0, 3'b000, 1);
    step(0, 0, 2'd0, 0, 3'b111, 0);

    // Simultaneous enqueue/dequeue at one entry; route switches next cycle.
    step(0, 1, 2'd0, 1, 3'b000, 0);
    step(0, 1, 2'd1, 0, 3'b001, 0);
    step(0, 0, 2'd0, 0, 3'b000, 0);
    step(0, 0, 2'd0, 0, 3'b000, 1);

    // Reset mid-operation with a full, requesting queue.
    step(0, 1, 2'd3, 1, 3'b000, 0);
    step(0, 1, 2'd2, 0, 3'b000, 0);
    step(1, 1, 2'd1, 1, 3'b000, 0);
    step(0, 1, 2'd3, 1, 3'b000, 0);
    step(0, 0, 2'd0, 0, 3'b000, 1);
    step(0, 0, 2'd0, 0, 3'b000, 0);

    // Random traffic with alternating-ish domains and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), 1'($urandom), 2'($urandom),
           1'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
